seq_shift_add_mult: RTL and testbench
=====================================

// Module: seq_shift_add_mult
// PURPOSE
//   Parametrised sequential shift-and-add (Russian-peasant) unsigned multiplier with start/busy/done handshake.
//   Generalises the fixed 8-bit datapath (swapper, shift registers, adder, result register, Moore sequencer) into one block.
//   Fed from switch/operand registers; product drives LEDs and the 7-segment display path.
// PARAMETERS
//   WIDTH   8   operand width in bits (>=2); product is 2*WIDTH bits.
//   Localparam CW = $clog2(WIDTH+2) is the iteration-counter width.
// PORTS
//   clk_100MHz  in   1        system clock, all logic on rising edge
//   reset       in   1        synchronous, active-high
//   start       in   1        level; sampled only in IDLE or DONE
//   a_in        in   WIDTH    multiplicand operand, sampled with start
//   b_in        in   WIDTH    multiplier operand, sampled with start
//   busy        out  1        1 while in RUN
//   done        out  1        one-cycle pulse in DONE
//   product     out  2*WIDTH  a*b; valid from done until next accepted start
//   iter_cnt    out  CW       RUN cycles spent on the last/current operation
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, product=0, iter_cnt=0; internal A, B, P cleared. Overrides everything, including mid-RUN.
//   State machine, encoded 2 bits:
//     IDLE: start=1 -> latch operands; A={WIDTH'b0, mcand}; B=mplier; P=0; iter_cnt=0 -> RUN.
//     RUN:  iter_cnt += 1 each cycle.
//           If B==0 or A==0 -> DONE; product<=P.
//           Else: if B[0], P<=P+A; A<=A<<1; B<=B>>1; stay in RUN. Add and shift happen in the same cycle.
//     DONE: done=1 for exactly one cycle -> IDLE. If start=1 here, operands are latched and the next state is RUN (back-to-back).
//   Timing: start sampled at edge k. RUN lasts N cycles, where N=1 if either operand is 0, else N=msb_index(mplier)+2.
//     done is high in the cycle after edge k+N.
//   Arithmetic: all unsigned. P and A are 2*WIDTH wide; the product cannot overflow.
//     A<<1 discards bits shifted past bit 2*WIDTH-1; those bits are zero for any reachable operand.
//   Safety cap: RUN also exits to DONE when iter_cnt reaches WIDTH+1, whatever the value of B.
//   start while busy=1: ignored; operands are not re-sampled.
//   product holds its value through IDLE; it updates only on the RUN->DONE transition; reset clears it.
//   The a_in/b_in inputs may change freely after the sampling edge.
// CONFIGURATION
//   MULT_OPERAND_SWAP_EN defined:
//     At the sampling edge, the larger of a_in/b_in becomes mcand and the smaller becomes mplier.
//     Equal operands: a_in is mcand. This minimises N.
//   MULT_OPERAND_SWAP_EN undefined:
//     mcand=a_in and mplier=b_in with no comparator; N depends on b_in only.
//   The product value is identical in both builds; only N and iter_cnt differ.
// TESTING
//   1 Reset: assert reset 2 cycles -> busy=0, done=0, product=0, iter_cnt=0.
//   2 WIDTH=8, a=5, b=3, start 1 cycle -> busy for 3 cycles; done pulse 1 cycle; product=15; iter_cnt=3.
//   3 a=3, b=128 -> product=384. Without SWAP_EN: iter_cnt=9. With SWAP_EN: iter_cnt=3.
//   4 a=0, b=200 and a=77, b=0 -> iter_cnt=1, product=0, done pulse; and a=255, b=255 -> product=65025.
//   5 Hold start high across DONE with new operands 12*10 -> RUN re-entered with no IDLE cycle; second product=120.
//     Also: a start pulse mid-RUN is ignored and the first result is unchanged.
//   6 Assert reset in the 2nd RUN cycle of 200*200 -> next cycle IDLE, all outputs 0.
//     A following start with 7*6 yields 42.
//   Scoreboard every done against a*b across random operands, for WIDTH=4, 8 and 16, in both macro builds.

Source files
------------

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier with a start/busy/done handshake.
// Optional build macro MULT_OPERAND_SWAP_EN puts the smaller operand in the multiplier slot.
module seq_shift_add_mult #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 2)
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [CW-1:0]      iter_cnt
);

    // Handshake: start is a level sampled only in IDLE or DONE; a_in/b_in are
    // captured on that same edge. busy is high for every RUN cycle, done pulses
    // for exactly one cycle, and product stays valid until the next accepted start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // iter_cnt value at the start of the last permitted RUN cycle
    localparam logic [CW-1:0] ITER_CAP = CW'(WIDTH);

    state_t             state;
    logic [2*WIDTH-1:0] a_reg;
    logic [2*WIDTH-1:0] p_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;

`ifdef MULT_OPERAND_SWAP_EN
    // Shorter multiplier means fewer RUN cycles; ties keep a_in as multiplicand.
    always_comb begin
        if (a_in >= b_in) begin
            mcand  = a_in;
            mplier = b_in;
        end else begin
            mcand  = b_in;
            mplier = a_in;
        end
    end
`else
    always_comb begin
        mcand  = a_in;
        mplier = b_in;
    end
`endif

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            iter_cnt <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            p_reg    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg    <= {{WIDTH{1'b0}}, mcand};
                        b_reg    <= mplier;
                        p_reg    <= '0;
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    iter_cnt <= iter_cnt + CW'(1);
                    // The cap only bounds the loop; reachable operands always empty B first.
                    if (b_reg == '0 || a_reg == '0 || iter_cnt == ITER_CAP) begin
                        product <= p_reg;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        if (b_reg[0]) begin
                            p_reg <= p_reg + a_reg;
                        end
                        a_reg <= a_reg << 1;
                        b_reg <= b_reg >> 1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: vector table, hand-written corner sequences,
// and random scoreboarded runs on WIDTH=8, 4 and 16 instances.
`timescale 1ns/1ps
module tb_seq_shift_add_mult;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 2);

    logic               clk_100MHz = 1'b0;
    logic               reset;
    logic               start;
    logic [W-1:0]       a_in, b_in;
    logic               busy, done;
    logic [2*W-1:0]     product;
    logic [CW-1:0]      iter_cnt;

    logic               start4, busy4, done4;
    logic [3:0]         a4, b4;
    logic [7:0]         prod4;
    logic [2:0]         iter4;

    logic               start16, busy16, done16;
    logic [15:0]        a16, b16;
    logic [31:0]        prod16;
    logic [4:0]         iter16;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [23:0] exp_q[$];
    logic [39:0] q4[$];
    logic [39:0] q16[$];
    logic [23:0] mon_e;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;
    vec_t vecs[8];

    seq_shift_add_mult #(.WIDTH(W)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .start(start),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .product(product), .iter_cnt(iter_cnt)
    );

    seq_shift_add_mult #(.WIDTH(4)) dut4 (
        .clk_100MHz(clk_100MHz), .reset(reset), .start(start4),
        .a_in(a4), .b_in(b4), .busy(busy4), .done(done4),
        .product(prod4), .iter_cnt(iter4)
    );

    seq_shift_add_mult #(.WIDTH(16)) dut16 (
        .clk_100MHz(clk_100MHz), .reset(reset), .start(start16),
        .a_in(a16), .b_in(b16), .busy(busy16), .done(done16),
        .product(prod16), .iter_cnt(iter16)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Expected RUN length: 1 for a zero operand, else msb index of the multiplier + 2.
    function automatic int exp_n(input int unsigned a, input int unsigned b);
        int unsigned mc, mp;
        int idx;
`ifdef MULT_OPERAND_SWAP_EN
        if (a >= b) begin mc = a; mp = b; end
        else begin mc = b; mp = a; end
`else
        mc = a;
        mp = b;
`endif
        if (mc == 0 || mp == 0) return 1;
        idx = 0;
        for (int i = 0; i < 32; i++) if (mp[i]) idx = i;
        return idx + 2;
    endfunction

    // Scoreboard for the WIDTH=8 instance: every done pops one expected record.
    always @(negedge clk_100MHz) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got product %0d, expected no done", product);
            end else begin
                mon_e = exp_q.pop_front();
                check("product", product, mon_e[15:0]);
                check("iter_cnt", iter_cnt, mon_e[23:16]);
                check("busy_in_done", busy, 0);
            end
        end
    end

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_100MHz);
            if (done === 1'b1) seen = 1;
        end
        check(name, seen, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p);
        int n, cyc;
        bit seen;
        n = exp_n(a, b);
        @(posedge clk_100MHz); #1;
        a_in = a; b_in = b; start = 1'b1;
        exp_q.push_back({8'(n), p});
        @(posedge clk_100MHz); #1;
        start = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        cyc = 0;
        seen = 0;
        for (int i = 0; i < 4*W + 8 && !seen; i++) begin
            @(negedge clk_100MHz);
            if (done === 1'b1) seen = 1;
            else if (busy === 1'b1) cyc++;
        end
        check("done_seen", seen, 1);
        check("busy_cycles", cyc, n);
        @(negedge clk_100MHz);
        check("done_pulse_width", done, 0);
        check("product_hold", product, p);
    endtask

    task automatic aux_op(input int which, input logic [15:0] a, input logic [15:0] b);
        logic [39:0] e;
        logic [31:0] p, got_p, got_i;
        bit seen;
        int n;
        string tag;
        tag = (which == 0) ? "w4" : "w16";
        p = 32'(a) * 32'(b);
        n = exp_n(a, b);
        @(posedge clk_100MHz); #1;
        if (which == 0) begin
            a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1;
            q4.push_back({8'(n), p});
        end else begin
            a16 = a; b16 = b; start16 = 1'b1;
            q16.push_back({8'(n), p});
        end
        @(posedge clk_100MHz); #1;
        start4 = 1'b0;
        start16 = 1'b0;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk_100MHz);
            if (((which == 0) ? done4 : done16) === 1'b1) seen = 1;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (which == 0) begin
            e = q4.pop_front();
            got_p = {24'b0, prod4};
            got_i = {29'b0, iter4};
        end else begin
            e = q16.pop_front();
            got_p = prod16;
            got_i = {27'b0, iter16};
        end
        check({tag, "_product"}, got_p, e[31:0]);
        check({tag, "_iter_cnt"}, got_i, e[39:32]);
    endtask

    initial begin
        logic [15:0] ra, rb;

        vecs[0] = '{a: 8'd5,   b: 8'd3,   p: 16'd15};
        vecs[1] = '{a: 8'd3,   b: 8'd128, p: 16'd384};
        vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
        vecs[3] = '{a: 8'd77,  b: 8'd0,   p: 16'd0};
        vecs[4] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
        vecs[5] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};
        vecs[6] = '{a: 8'd128, b: 8'd3,   p: 16'd384};
        vecs[7] = '{a: 8'd200, b: 8'd201, p: 16'd40200};

        reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;

        // Reset state
        repeat (2) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        check("rst_iter_cnt", iter_cnt, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

        // Start held across DONE with new operands: RUN is re-entered directly
        @(posedge clk_100MHz); #1;
        a_in = 8'd9; b_in = 8'd7; start = 1'b1;
        exp_q.push_back({8'(exp_n(9, 7)), 16'd63});
        @(posedge clk_100MHz); #1;
        a_in = 8'd12; b_in = 8'd10;
        exp_q.push_back({8'(exp_n(12, 10)), 16'd120});
        wait_done("b2b_first_done");
        @(negedge clk_100MHz);
        check("b2b_no_idle", busy, 1);
        start = 1'b0;
        wait_done("b2b_second_done");

        // Start pulse mid-RUN must be ignored
        @(posedge clk_100MHz); #1;
        a_in = 8'd200; b_in = 8'd201; start = 1'b1;
        exp_q.push_back({8'(exp_n(200, 201)), 16'd40200});
        @(posedge clk_100MHz); #1;
        start = 1'b0; a_in = 8'd1; b_in = 8'd1;
        @(posedge clk_100MHz); #1;
        start = 1'b1;
        @(posedge clk_100MHz); #1;
        start = 1'b0;
        wait_done("midrun_done");
        repeat (12) @(negedge clk_100MHz);
        check("midrun_queue_drained", exp_q.size(), 0);

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            run_op(ra[7:0], rb[7:0], ra * rb);
        end

        aux_op(0, 16'd15, 16'd15);
        aux_op(0, 16'd0, 16'd9);
        aux_op(1, 16'hFFFF, 16'hFFFF);
        aux_op(1, 16'd5, 16'd0);
        for (int i = 0; i < 20; i++) begin
            aux_op(0, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)));
            aux_op(1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end

        // Reset in the second RUN cycle clears everything, then a fresh op works
        run_op(8'd9, 8'd9, 16'd81);
        @(posedge clk_100MHz); #1;
        a_in = 8'd200; b_in = 8'd200; start = 1'b1;
        @(posedge clk_100MHz); #1;
        start = 1'b0;
        @(posedge clk_100MHz); #1;
        reset = 1'b1;
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", product, 0);
        check("midrst_iter_cnt", iter_cnt, 0);
        reset = 1'b0;
        run_op(8'd7, 8'd6, 16'd42);

        repeat (4) @(negedge clk_100MHz);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
